// File: rtl/cmp_share_arbiter.sv
// Round-robin sharing of one pipelined FP comparator among NREQ requesters.
// A tag pipeline follows each issued operand pair so its result returns to the issuer.
module cmp_share_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned width   = 23,
  parameter int unsigned CMP_LAT = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_en,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*(width+1)-1:0]  req_a,
  input  logic [NREQ*(width+1)-1:0]  req_b,
  output logic [width:0]             cmp_a,
  output logic [width:0]             cmp_b,
  input  logic                       cmp_greater,
  output logic [NREQ-1:0]            rsp_valid,
  output logic                       rsp_greater,
  output logic                       busy
);
  localparam int unsigned W  = width + 1;
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned TD = CMP_LAT + 1;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   gnt_idx;
  logic            gnt_any;
  logic [W-1:0]    cmp_a_q, cmp_a_d;
  logic [W-1:0]    cmp_b_q, cmp_b_d;
  logic [TD-1:0]   tag_v_q;
  logic [PW-1:0]   tag_id_q [TD];
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic            rsp_greater_q, rsp_greater_d;

  // Rotating priority scan starting at ptr_q; first requester found wins.
  always_comb begin
    int unsigned idx;
    logic [PW-1:0] idx_p;
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    req_ready = '0;
    idx       = 0;
    idx_p     = '0;
    if (rst && issue_en) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        idx = 32'(ptr_q) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        idx_p = PW'(idx);
        if (!gnt_any && req_valid[idx_p]) begin
          gnt_any = 1'b1;
          gnt_idx = idx_p;
        end
      end
    end
    if (gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    int unsigned nxt;
    nxt = 32'(gnt_idx) + 1;
    if (nxt >= NREQ) nxt = 0;
    ptr_d   = ptr_q;
    cmp_a_d = cmp_a_q;
    cmp_b_d = cmp_b_q;
    if (gnt_any) begin
      ptr_d   = PW'(nxt);
      cmp_a_d = req_a[32'(gnt_idx)*W +: W];
      cmp_b_d = req_b[32'(gnt_idx)*W +: W];
    end
  end

  // Stage 0 is loaded with the operands; the head lines up with cmp_greater,
  // giving CMP_LAT+1 stages so the response registers one edge later.
  always_comb begin
    rsp_valid_d = '0;
    if (tag_v_q[TD-1]) rsp_valid_d[tag_id_q[TD-1]] = 1'b1;
    rsp_greater_d = tag_v_q[TD-1] & cmp_greater;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q         <= '0;
      cmp_a_q       <= '0;
      cmp_b_q       <= '0;
      tag_v_q       <= '0;
      rsp_valid_q   <= '0;
      rsp_greater_q <= 1'b0;
      for (int unsigned s = 0; s < TD; s++) tag_id_q[s] <= '0;
    end else begin
      ptr_q         <= ptr_d;
      cmp_a_q       <= cmp_a_d;
      cmp_b_q       <= cmp_b_d;
      tag_v_q       <= {tag_v_q[TD-2:0], gnt_any};
      tag_id_q[0]   <= gnt_idx;
      for (int unsigned s = 1; s < TD; s++) tag_id_q[s] <= tag_id_q[s-1];
      rsp_valid_q   <= rsp_valid_d;
      rsp_greater_q <= rsp_greater_d;
    end
  end

  assign cmp_a       = cmp_a_q;
  assign cmp_b       = cmp_b_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_greater = rsp_greater_q;
  assign busy        = |tag_v_q;

endmodule
